i2s_fifo_bridge_ctrl: RTL
=========================

// Module: i2s_fifo_bridge_ctrl
// PURPOSE
//  Sequences word transfers between the APB data window and the I2S Tx/Rx FIFOs.
//  Owns one Tx holding word and one Rx holding word, and tracks their occupancy.
//  Holds off APB accesses with pready wait states, then times them out with pslverr.
//  Counts overrun/underrun errors and raises a level interrupt to the CPU.
// PARAMETERS
//  DATA_W      32    FIFO/APB data width
//  ADDR_W      8     APB address width
//  WAIT_MAX    16    stalled access cycles before timeout (>=1)
//  CNT_W       8     error counter width (<=8), saturating
// PORTS
//  pclk           in   1        APB clock; all logic on posedge
//  preset         in   1        reset, asynchronous, active-low
//  psel           in   1        APB select
//  penable        in   1        APB access phase
//  pwrite         in   1        1=write, 0=read
//  paddr          in   ADDR_W   byte address
//  pwdata         in   DATA_W   write data
//  prdata         out  DATA_W   read data (combinational, valid when pready=1)
//  pready         out  1        access completes when high
//  pslverr        out  1        access error, qualified by pready
//  tx_fifo_full   in   1        Tx FIFO cannot accept
//  tx_fifo_wen    out  1        one-cycle Tx FIFO push strobe
//  tx_fifo_wdata  out  DATA_W   Tx holding word
//  rx_fifo_empty  in   1        Rx FIFO has no data
//  rx_fifo_ren    out  1        one-cycle Rx FIFO pop strobe
//  rx_fifo_rdata  in   DATA_W   valid the cycle after rx_fifo_ren
//  irq            out  1        registered level interrupt
// BEHAVIOUR
//  Map: 0x04 TXDATA (W), 0x08 RXDATA (R), 0x0C IRQ_EN (RW, bits[2:0]), 0x10 STATUS (R; write clears).
//  STATUS: [23:16] udr_cnt, [15:8] ovr_cnt, [3] err, [2] rx_full, [1] tx_occ, [0] tx_fifo_full.
//  Other addresses: pready=1, pslverr=0, prdata=0. These are decoded by the parent.
//  Access = psel&penable. pready=1 except during stalled TXDATA/RXDATA accesses.
//  Reset: tx_fifo_wen=0, rx_fifo_ren=0, irq=0, holding words=0, counters=0, IRQ_EN=0, FSMs idle.
//  Reset mid-operation: held words are discarded and any strobe drops immediately.
//  Tx FSM TX_EMPTY->TX_HELD->TX_EMPTY:
//   - TXDATA write in TX_EMPTY: pready=1, word latched at that edge, go to TX_HELD.
//   - In TX_HELD with !tx_fifo_full: tx_fifo_wen<=1 for exactly 1 cycle, go to TX_EMPTY.
//   - TXDATA write in TX_HELD: pready=0. It completes normally once TX_EMPTY is reached.
//  Rx FSM RX_IDLE->RX_REQ->RX_CAP->RX_FULL:
//   - RX_IDLE with !rx_fifo_empty: next cycle RX_REQ, rx_fifo_ren=1 for exactly 1 cycle.
//   - RX_CAP latches rx_fifo_rdata.
//   - RXDATA read in RX_FULL: prdata=hold, pready=1, go to RX_IDLE.
//   - A new fetch starts no earlier than the cycle after RX_IDLE is entered.
//  Timeout: wait_cnt increments on each stalled access cycle.
//   - At wait_cnt==WAIT_MAX: pready=1, pslverr=1, err<=1.
//   - Write timeout: word is dropped, ovr_cnt+1.
//   - Read timeout: prdata=0, udr_cnt+1.
//   - wait_cnt clears whenever the access ends.
//  Counters saturate at 2^CNT_W-1.
//  A STATUS write clears the counters and err. If an increment coincides with the clear, the counter becomes 1.
//  irq <= (EN[0]&TX_EMPTY) | (EN[1]&RX_FULL) | (EN[2]&err), updated every edge.
// TESTING
//  1. Write TXDATA=0xA5A5_0001 with FIFO not full -> pready=1 in the first access cycle.
//     tx_fifo_wen is a 1-cycle pulse with wdata=0xA5A5_0001 two edges after acceptance.
//  2. Hold tx_fifo_full=1 and write twice -> the 2nd write stalls.
//     Release full after 5 cycles -> the 2nd write completes with pslverr=0 and both words are pushed in order.
//  3. Keep full=1 with WAIT_MAX=16 -> the 2nd write ends after 17 access cycles with pslverr=1.
//     STATUS ovr_cnt=1, err=1.
//  4. rx_fifo_empty falls with rdata=0x1234_5678 -> single ren pulse.
//     Read RXDATA returns 0x1234_5678, then the next fetch starts.
//  5. Read RXDATA with Rx empty for 16 cycles -> pslverr=1, prdata=0, udr_cnt=1.
//     Force 300 underruns -> udr_cnt=255. STATUS write -> 0.
//  6. IRQ_EN=3'b010 with a word fetched -> irq=1. Read RXDATA -> irq=0.
//     Assert preset mid-push -> wen=0 and irq=0 immediately.

Source files
------------

// File: rtl/i2s_fifo_bridge_ctrl_if.sv
// APB bus bundle for the I2S FIFO bridge controller.
//   master : drives psel/penable/pwrite/paddr/pwdata, samples prdata/pready/pslverr
//   slave  : the opposite direction (used by i2s_fifo_bridge_ctrl)
`timescale 1ns/1ps
interface i2s_fifo_bridge_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/i2s_fifo_bridge_ctrl.sv
// I2S FIFO bridge controller.
// Moves single words between the APB data window and the I2S Tx/Rx FIFOs through
// one Tx holding word and one Rx holding word. Accesses that cannot be served
// yet are stretched with pready=0 and abandoned with pslverr after WAIT_MAX
// stalled cycles; such timeouts are counted as overruns (Tx) or underruns (Rx).
// Ports:
//   pclk, preset          clock (posedge) and asynchronous active-low reset
//   apb (slave modport)   psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out
//   tx_fifo_full in       Tx FIFO cannot accept
//   tx_fifo_wen/wdata out one-cycle push strobe and Tx holding word
//   rx_fifo_empty in      Rx FIFO has no data
//   rx_fifo_ren out       one-cycle pop strobe
//   rx_fifo_rdata in      pop data, valid the cycle after rx_fifo_ren
//   irq out               registered level interrupt
// Register map: 0x04 TXDATA (W), 0x08 RXDATA (R), 0x0C IRQ_EN (RW [2:0]),
//               0x10 STATUS (R, write clears counters and err).
`timescale 1ns/1ps
module i2s_fifo_bridge_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    i2s_fifo_bridge_ctrl_if.slave apb,
    input  logic                  tx_fifo_full,
    output logic                  tx_fifo_wen,
    output logic [DATA_W-1:0]     tx_fifo_wdata,
    input  logic                  rx_fifo_empty,
    output logic                  rx_fifo_ren,
    input  logic [DATA_W-1:0]     rx_fifo_rdata,
    output logic                  irq
);
    localparam logic [ADDR_W-1:0] ADDR_TX     = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] ADDR_RX     = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(8'h10);
    localparam int                WC_W        = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0]   WAIT_LIMIT  = WC_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    typedef enum logic {TX_EMPTY, TX_HELD} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_REQ, RX_CAP, RX_FULL} rx_state_t;

    tx_state_t         tx_state_reg;
    rx_state_t         rx_state_reg;
    logic [DATA_W-1:0] tx_hold_reg;
    logic [DATA_W-1:0] rx_hold_reg;
    logic [WC_W-1:0]   wait_cnt_reg;
    logic [2:0]        irq_en_reg;
    logic              err_reg;

    // ---------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------
    logic access, tx_wr, rx_rd, en_wr, status_clr;
    logic tx_stall, rx_stall, stall, timeout;
    logic tx_accept, rx_take, ovr_inc, udr_inc;

    assign access     = apb.psel & apb.penable;
    assign tx_wr      = access &  apb.pwrite & (apb.paddr == ADDR_TX);
    assign rx_rd      = access & ~apb.pwrite & (apb.paddr == ADDR_RX);
    assign en_wr      = access &  apb.pwrite & (apb.paddr == ADDR_IRQ_EN);
    assign status_clr = access &  apb.pwrite & (apb.paddr == ADDR_STATUS);

    assign tx_stall   = tx_wr & (tx_state_reg == TX_HELD);
    assign rx_stall   = rx_rd & (rx_state_reg != RX_FULL);
    assign stall      = tx_stall | rx_stall;
    // The stalled access is released with an error on the cycle the
    // counter has already seen WAIT_MAX stalled cycles.
    assign timeout    = stall & (wait_cnt_reg == WAIT_LIMIT);

    assign tx_accept  = tx_wr & (tx_state_reg == TX_EMPTY);
    assign rx_take    = rx_rd & (rx_state_reg == RX_FULL);
    assign ovr_inc    = timeout & tx_stall;
    assign udr_inc    = timeout & rx_stall;

    assign apb.pready  = ~stall | timeout;
    assign apb.pslverr = timeout;

    // ---------------------------------------------------------------
    // Saturating error counters: [0] overrun, [1] underrun
    // ---------------------------------------------------------------
    logic [1:0] cnt_inc;
    assign cnt_inc = {udr_inc, ovr_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge pclk or negedge preset) begin
                if (!preset) begin
                    cnt_reg <= '0;
                end else if (status_clr) begin
                    // A coincident event survives the clear as a count of one.
                    cnt_reg <= cnt_inc[gi] ? CNT_W'(1) : '0;
                end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    logic [CNT_W-1:0] ovr_cnt, udr_cnt;
    assign ovr_cnt = g_cnt[0].cnt_reg;
    assign udr_cnt = g_cnt[1].cnt_reg;

    // ---------------------------------------------------------------
    // Read data mux
    // ---------------------------------------------------------------
    logic [31:0] status_word;
    assign status_word = {8'h00, 8'(udr_cnt), 8'(ovr_cnt), 4'h0, err_reg,
                          (rx_state_reg == RX_FULL), (tx_state_reg == TX_HELD),
                          tx_fifo_full};

    always_comb begin
        apb.prdata = '0;
        if (access && !apb.pwrite) begin
            case (apb.paddr)
                ADDR_RX:     apb.prdata = rx_take ? rx_hold_reg : '0;
                ADDR_IRQ_EN: apb.prdata = DATA_W'(irq_en_reg);
                ADDR_STATUS: apb.prdata = DATA_W'(status_word);
                default:     apb.prdata = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Wait-state counter: runs only while an access is being stalled
    // ---------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            wait_cnt_reg <= '0;
        end else if (stall && !timeout) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // ---------------------------------------------------------------
    // Tx FSM: one holding word, pushed as soon as the FIFO has room
    // ---------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            tx_state_reg <= TX_EMPTY;
            tx_hold_reg  <= '0;
            tx_fifo_wen  <= 1'b0;
        end else begin
            tx_fifo_wen <= 1'b0;
            case (tx_state_reg)
                TX_EMPTY: begin
                    if (tx_accept) begin
                        tx_hold_reg  <= apb.pwdata;
                        tx_state_reg <= TX_HELD;
                    end
                end
                TX_HELD: begin
                    // Holding word stays on wdata through the push cycle.
                    if (!tx_fifo_full) begin
                        tx_fifo_wen  <= 1'b1;
                        tx_state_reg <= TX_EMPTY;
                    end
                end
                default: tx_state_reg <= TX_EMPTY;
            endcase
        end
    end

    assign tx_fifo_wdata = tx_hold_reg;

    // ---------------------------------------------------------------
    // Rx FSM: pop one word, capture it a cycle later, hold until read
    // ---------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            rx_state_reg <= RX_IDLE;
            rx_hold_reg  <= '0;
            rx_fifo_ren  <= 1'b0;
        end else begin
            rx_fifo_ren <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_fifo_empty) begin
                        rx_fifo_ren  <= 1'b1;
                        rx_state_reg <= RX_REQ;
                    end
                end
                RX_REQ: rx_state_reg <= RX_CAP;
                RX_CAP: begin
                    rx_hold_reg  <= rx_fifo_rdata;
                    rx_state_reg <= RX_FULL;
                end
                RX_FULL: begin
                    if (rx_take) begin
                        rx_state_reg <= RX_IDLE;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Control registers, sticky error flag and interrupt
    // ---------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            irq_en_reg <= 3'b000;
            err_reg    <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (en_wr) begin
                irq_en_reg <= apb.pwdata[2:0];
            end
            if (timeout) begin
                err_reg <= 1'b1;
            end else if (status_clr) begin
                err_reg <= 1'b0;
            end
            irq <= (irq_en_reg[0] & (tx_state_reg == TX_EMPTY)) |
                   (irq_en_reg[1] & (rx_state_reg == RX_FULL))  |
                   (irq_en_reg[2] & err_reg);
        end
    end
endmodule
